// File: rtl/maf_pkg.sv
// maf_pkg: shared definitions for the MAF normalise-prep stage.
//  - Mode encodings for cont[1:0]. Any value with cont[1] set is fused.
//  - Default geometry (LANES/EW/PW/SHW/CW).
//  - payload_w(): width of the flattened entry held in the skid buffer.
package maf_pkg;

  localparam logic [1:0] MODE_FUSED1     = 2'b00;
  localparam logic [1:0] MODE_SPLIT      = 2'b01;
  localparam int         MODE_FUSED3_BIT = 1;     // cont[1]=1 -> fused

  localparam int DEF_LANES = 2;
  localparam int DEF_EW    = 6;
  localparam int DEF_PW    = 74;
  localparam int DEF_SHW   = 5;
  localparam int DEF_CW    = 3;

  // Entry layout: {cont, p, sh, esh, revi, sgn, spc, d, e, uflow}
  function automatic int payload_w(int lanes, int ew, int pw, int shw, int cw);
    return cw + pw + lanes*shw + 3*lanes + 3*lanes + 2*lanes*ew + lanes;
  endfunction

  // Split only for exactly 01; cont[1] wins, so 11 stays fused.
  function automatic logic is_split(logic [1:0] mode);
    return (mode == MODE_SPLIT);
  endfunction

endpackage

// File: rtl/maf_exp_adj.sv
// maf_exp_adj: combinational segmented exponent correction e = epre - revi.
//  Fused mode: one LANES*EW-bit subtraction of revi[0]; borrow on uflow[0].
//  Split mode: LANES independent EW-bit subtractions, segment k uses revi[k];
//              the borrow chain is cut between segments, uflow[k] per segment.
//  Optional macro MAF_EXP_SAT_EN: a segment (fused: the whole word) that
//  borrows is forced to 0 instead of wrapping; uflow is reported either way.
// Ports:
//  mode  in  2          cont[1:0]
//  epre  in  LANES*EW   precomputed exponent
//  revi  in  LANES      per-lane LZA revise bit
//  e     out LANES*EW   corrected exponent
//  uflow out LANES      borrow out(s)
module maf_exp_adj
  import maf_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int EW    = DEF_EW
) (
  input  logic [1:0]          mode,
  input  logic [LANES*EW-1:0] epre,
  input  logic [LANES-1:0]    revi,
  output logic [LANES*EW-1:0] e,
  output logic [LANES-1:0]    uflow
);

  logic split;
  assign split = is_split(mode);

  always_comb begin
    logic             bin;
    logic [EW:0]      seg;
    logic [LANES-1:0] bout;
    e     = '0;
    uflow = '0;
    bout  = '0;
    bin   = 1'b0;
    seg   = '0;
    for (int k = 0; k < LANES; k++) begin
      // Split: each segment starts fresh with its own revise bit.
      // Fused: segment 0 takes revi[0], later segments ripple the borrow.
      if (split)       bin = revi[k];
      else if (k == 0) bin = revi[0];
      seg             = {1'b0, epre[k*EW +: EW]} - {{EW{1'b0}}, bin};
      e[k*EW +: EW]   = seg[EW-1:0];
      bout[k]         = seg[EW];
      bin             = seg[EW];
    end
    if (split) uflow    = bout;
    else       uflow[0] = bout[LANES-1];
`ifdef MAF_EXP_SAT_EN
    if (split) begin
      for (int k = 0; k < LANES; k++)
        if (bout[k]) e[k*EW +: EW] = '0;
    end else if (bout[LANES-1]) begin
      e = '0;
    end
`endif
  end

endmodule

// File: rtl/maf_norm_stage.sv
// maf_norm_stage: T4_3 stage of the multi-precision MAF pipeline.
//  Computes the corrected exponent on input (maf_exp_adj), then stores it
//  with the rest of the entry in a 2-entry skid buffer (main + skid).
//  Latency 1: an entry accepted at edge N is on the outputs after edge N.
//  in_ready is registered (= !skid valid), so out_ready never reaches it
//  combinationally. flush empties both entries; rst beats flush.
//  Payload outputs hold when out_valid=0; only reset zeroes them.
//  Optional macro MAF_EXP_SAT_EN (see maf_exp_adj): saturate on borrow.
// Ports:
//  clk, rst (sync, active high), flush
//  in_valid/in_ready, cont_in, p_in, sh_in, esh_in, revi_in, epre_in,
//  sgn_in, spc_in, d_in                          upstream entry
//  out_valid/out_ready, *_out registered copies, e_out, uflow_out
module maf_norm_stage
  import maf_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int EW    = DEF_EW,
  parameter int PW    = DEF_PW,
  parameter int SHW   = DEF_SHW,
  parameter int CW    = DEF_CW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CW-1:0]          cont_in,
  input  logic [PW-1:0]          p_in,
  input  logic [LANES*SHW-1:0]   sh_in,
  input  logic [LANES-1:0]       esh_in,
  input  logic [LANES-1:0]       revi_in,
  input  logic [LANES*EW-1:0]    epre_in,
  input  logic [LANES-1:0]       sgn_in,
  input  logic [3*LANES-1:0]     spc_in,
  input  logic [LANES*EW-1:0]    d_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          cont_out,
  output logic [PW-1:0]          p_out,
  output logic [LANES*SHW-1:0]   sh_out,
  output logic [LANES-1:0]       esh_out,
  output logic [LANES-1:0]       revi_out,
  output logic [LANES-1:0]       sgn_out,
  output logic [3*LANES-1:0]     spc_out,
  output logic [LANES*EW-1:0]    d_out,
  output logic [LANES*EW-1:0]    e_out,
  output logic [LANES-1:0]       uflow_out
);

  localparam int PLW = payload_w(LANES, EW, PW, SHW, CW);

  logic [LANES*EW-1:0] e_in;
  logic [LANES-1:0]    uf_in;

  maf_exp_adj #(.LANES(LANES), .EW(EW)) u_exp_adj (
    .mode  (cont_in[1:0]),
    .epre  (epre_in),
    .revi  (revi_in),
    .e     (e_in),
    .uflow (uf_in)
  );

  logic [PLW-1:0] pl_in;
  assign pl_in = {cont_in, p_in, sh_in, esh_in, revi_in, sgn_in, spc_in, d_in, e_in, uf_in};

  logic [PLW-1:0] main_q, main_d, skid_q, skid_d;
  logic           main_vld_q, main_vld_d;
  logic           skid_vld_q, skid_vld_d;
  logic           in_ready_q, in_ready_d;
  logic           acc, drain;

  always_comb begin
    acc        = in_valid & in_ready_q & ~flush;
    drain      = main_vld_q & out_ready;
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_vld_q && !drain) begin
      // Main is held: a new entry parks in skid (in_ready implies skid empty).
      if (acc) begin
        skid_d     = pl_in;
        skid_vld_d = 1'b1;
      end
    end else if (skid_vld_q) begin
      // Main drains (or is empty): skid moves up; no accept possible here.
      main_d     = skid_q;
      main_vld_d = 1'b1;
      skid_vld_d = 1'b0;
    end else begin
      // Main empty or draining with skid empty: new entry goes straight to main.
      main_vld_d = acc;
      if (acc) main_d = pl_in;
    end
    in_ready_d = ~skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_valid = main_vld_q;
  assign in_ready  = in_ready_q;
  assign {cont_out, p_out, sh_out, esh_out, revi_out, sgn_out, spc_out,
          d_out, e_out, uflow_out} = main_q;

endmodule

// File: tb/tb_maf_norm_stage.sv
module tb_maf_norm_stage;
  localparam int LANES = 2, EW = 6, PW = 74, SHW = 5, CW = 3;
  localparam int XW = LANES*EW;

  typedef struct packed {
    logic [CW-1:0]        cont;
    logic [PW-1:0]        p;
    logic [LANES*SHW-1:0] sh;
    logic [LANES-1:0]     esh;
    logic [LANES-1:0]     revi;
    logic [LANES-1:0]     sgn;
    logic [3*LANES-1:0]   spc;
    logic [XW-1:0]        d;
    logic [XW-1:0]        e;
    logic [LANES-1:0]     uf;
  } ent_t;
  localparam int OW = $bits(ent_t);

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic in_ready, out_valid;
  ent_t drv;
  logic [XW-1:0] epre_drv;
  logic [CW-1:0]        cont_out;
  logic [PW-1:0]        p_out;
  logic [LANES*SHW-1:0] sh_out;
  logic [LANES-1:0]     esh_out, revi_out, sgn_out, uflow_out;
  logic [3*LANES-1:0]   spc_out;
  logic [XW-1:0]        d_out, e_out;
  logic [OW-1:0]        out_bus;

  always #5 clk = ~clk;

  maf_norm_stage #(.LANES(LANES), .EW(EW), .PW(PW), .SHW(SHW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .cont_in(drv.cont), .p_in(drv.p), .sh_in(drv.sh), .esh_in(drv.esh),
    .revi_in(drv.revi), .epre_in(epre_drv), .sgn_in(drv.sgn), .spc_in(drv.spc),
    .d_in(drv.d),
    .out_valid(out_valid), .out_ready(out_ready),
    .cont_out(cont_out), .p_out(p_out), .sh_out(sh_out), .esh_out(esh_out),
    .revi_out(revi_out), .sgn_out(sgn_out), .spc_out(spc_out), .d_out(d_out),
    .e_out(e_out), .uflow_out(uflow_out)
  );

  assign out_bus = {cont_out, p_out, sh_out, esh_out, revi_out, sgn_out,
                    spc_out, d_out, e_out, uflow_out};

  ent_t q[$];
  int   n_cmp = 0, n_bad = 0, n_out = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain wide subtraction per mode.
  task automatic model(input logic [CW-1:0] c, input logic [XW-1:0] ep,
                       input logic [LANES-1:0] rv,
                       output logic [XW-1:0] e, output logic [LANES-1:0] uf);
    logic [XW:0] full;
    logic [EW:0] s;
    e = '0; uf = '0;
    if (c[1:0] == 2'b01) begin
      for (int k = 0; k < LANES; k++) begin
        s = {1'b0, ep[k*EW +: EW]} - {{EW{1'b0}}, rv[k]};
        e[k*EW +: EW] = s[EW-1:0];
        uf[k] = s[EW];
`ifdef MAF_EXP_SAT_EN
        if (s[EW]) e[k*EW +: EW] = '0;
`endif
      end
    end else begin
      full = {1'b0, ep} - {{XW{1'b0}}, rv[0]};
      e = full[XW-1:0];
      uf[0] = full[XW];
`ifdef MAF_EXP_SAT_EN
      if (full[XW]) e = '0;
`endif
    end
  endtask

  logic [XW-1:0] pend_epre;
  task automatic mk(input logic [CW-1:0] c, input logic [XW-1:0] ep,
                    input logic [LANES-1:0] rv, output ent_t x);
    x.cont = c;
    x.p    = PW'({$urandom, $urandom, $urandom});
    x.sh   = (LANES*SHW)'($urandom);
    x.esh  = LANES'($urandom);
    x.revi = rv;
    x.sgn  = LANES'($urandom);
    x.spc  = (3*LANES)'($urandom);
    x.d    = XW'($urandom);
    model(c, ep, rv, x.e, x.uf);
    pend_epre = ep;
  endtask

  // One cycle: observe handshakes at negedge, advance to 1 time unit past posedge.
  task automatic step();
    ent_t x;
    @(negedge clk);
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", {255'b0, out_valid}, 256'd0);
        else begin
          x = q.pop_front();
          chk("payload", out_bus, x);
          chk("e_out", e_out, x.e);
          chk("uflow_out", uflow_out, x.uf);
          n_out++;
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(drv);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input ent_t x, output int waits);
    drv = x; epre_drv = pend_epre; in_valid = 1'b1; waits = 0;
    while (!in_ready && waits < 20) begin step(); waits++; end
    if (waits >= 20) chk("send_timeout", {255'b0, in_ready}, 256'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 20) begin step(); n++; end
    chk("drain_left", q.size(), 0);
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t a, b, c, x;
    int w, t0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drv = '0; epre_drv = '0; pend_epre = '0;
    step(); step();
    chk("rst_outs", out_bus, 0);
    chk("rst_out_valid", {255'b0, out_valid}, 0);
    chk("rst_in_ready", {255'b0, in_ready}, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {255'b0, in_ready}, 1);

    // 1: fused, 0x040 - 1
    out_ready = 1'b0;
    chk("t1_pre_valid", {255'b0, out_valid}, 0);
    mk(3'b000, 12'h040, 2'b01, x); send(x, w);
    chk("t1_lat_valid", {255'b0, out_valid}, 1);
    chk("t1_e", e_out, 12'h03F);
    chk("t1_uf", uflow_out, 2'b00);
    drain_all();

    // 2: split, borrow in low segment only
    out_ready = 1'b0;
    mk(3'b001, {6'h05, 6'h00}, 2'b11, x); send(x, w);
`ifdef MAF_EXP_SAT_EN
    chk("t2_e", e_out, {6'h04, 6'h00});
`else
    chk("t2_e", e_out, {6'h04, 6'h3F});
`endif
    chk("t2_uf", uflow_out, 2'b01);
    drain_all();

    // mode 11 is fused: borrow ripples through the whole word
    out_ready = 1'b0;
    mk(3'b011, 12'h000, 2'b01, x); send(x, w);
`ifdef MAF_EXP_SAT_EN
    chk("m11_e", e_out, 12'h000);
`else
    chk("m11_e", e_out, 12'hFFF);
`endif
    chk("m11_uf", uflow_out, 2'b01);
    drain_all();

    // 3: stall with A, B, C
    out_ready = 1'b0;
    mk(3'b001, XW'($urandom), 2'b10, a); send(a, w);
    mk(3'b000, XW'($urandom), 2'b01, b); send(b, w);
    chk("t3_in_ready", {255'b0, in_ready}, 0);
    chk("t3_held_valid", {255'b0, out_valid}, 1);
    chk("t3_held_e", e_out, a.e);
    mk(3'b100, XW'($urandom), 2'b11, c);
    drv = c; epre_drv = pend_epre; in_valid = 1'b1;
    step();
    chk("t3_stall_ready", {255'b0, in_ready}, 0);
    chk("t3_stall_p", p_out, a.p);
    out_ready = 1'b1;
    send(c, w);
    drain_all();

    // 4: 16 back-to-back with random modes/exponents
    out_ready = 1'b1;
    t0 = n_out;
    for (int i = 0; i < 16; i++) begin
      mk(CW'($urandom), XW'($urandom_range(0, 3) == 0 ? 0 : $urandom),
         LANES'($urandom), x);
      send(x, w);
      chk("t4_no_stall", w, 0);
    end
    step();
    chk("t4_count", n_out - t0, 16);
    drain_all();

    // 5: flush when full with an offered entry
    out_ready = 1'b0;
    mk(3'b000, XW'($urandom), 2'b01, a); send(a, w);
    mk(3'b001, XW'($urandom), 2'b11, b); send(b, w);
    mk(3'b000, XW'($urandom), 2'b00, c);
    drv = c; epre_drv = pend_epre; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", {255'b0, out_valid}, 0);
    chk("t5_in_ready", {255'b0, in_ready}, 1);
    t0 = n_out;
    out_ready = 1'b1;
    repeat (4) step();
    chk("t5_no_out", n_out - t0, 0);

    // 6: reset with two entries buffered
    out_ready = 1'b0;
    mk(3'b001, XW'($urandom), 2'b01, a); send(a, w);
    mk(3'b000, XW'($urandom), 2'b10, b); send(b, w);
    rst = 1'b1;
    step();
    chk("t6_outs", out_bus, 0);
    chk("t6_valid", {255'b0, out_valid}, 0);
    chk("t6_in_ready", {255'b0, in_ready}, 0);
    rst = 1'b0;
    step();
    chk("t6_in_ready_after", {255'b0, in_ready}, 1);
    t0 = n_out;
    mk(3'b000, 12'h800, 2'b01, x); send(x, w);
    chk("t6_first_e", e_out, 12'h7FF);
    drain_all();
    chk("t6_one_out", n_out - t0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
